// File: rtl/tl_a_arb2_ctrl_pkg.sv
// Shared types, field layout and beat-count helper for the 2:1 TL-UL A/D arbiter.
// A: {opcode, param, size, source, address, mask, data}; D: {opcode, param, size, source, denied, data}.
package tl_a_arb2_ctrl_pkg;

    localparam int SRC_W    = 4;
    localparam int SZ_W     = 3;
    localparam int MAX_SIZE = 6;
    localparam int CNT_W    = MAX_SIZE - 3;
    localparam int BEAT_W   = MAX_SIZE - 2;

    typedef enum logic [2:0] {
        OP_PUT_FULL    = 3'd0,
        OP_PUT_PARTIAL = 3'd1,
        OP_ARITH       = 3'd2,
        OP_LOGICAL     = 3'd3,
        OP_GET         = 3'd4,
        OP_INTENT      = 3'd5
    } tl_a_op_e;

    localparam int A_SRC_LSB  = 64 + 8 + 32;
    localparam int A_SIZE_LSB = A_SRC_LSB + SRC_W;
    localparam int A_OPC_LSB  = A_SIZE_LSB + SZ_W + 3;
    localparam int A_W        = A_OPC_LSB + 3;

    localparam int D_SRC_LSB  = 64 + 1;
    localparam int D_W        = D_SRC_LSB + SRC_W + SZ_W + 2 + 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Oversized requests are clamped so the burst counter never wraps.
    function automatic logic [BEAT_W-1:0] tl_beats(
        input logic [2:0]      opcode,
        input logic [SZ_W-1:0] size
    );
        logic [SZ_W-1:0]   s;
        logic [BEAT_W-1:0] b;
        s = (size > SZ_W'(MAX_SIZE)) ? SZ_W'(MAX_SIZE) : size;
        b = BEAT_W'(1);
        if (opcode <= OP_LOGICAL && s > SZ_W'(3))
            b = BEAT_W'(1) << (s - SZ_W'(3));
        return b;
    endfunction

endpackage

// File: rtl/tl_a_arb2_ctrl_if.sv
// Handshake bundle for the 2:1 arbiter: two A requesters, shared A/D slave side,
// and the D fan-out back to both requesters.
interface tl_a_arb2_ctrl_if;
    import tl_a_arb2_ctrl_pkg::*;

    logic           a0_valid;
    logic           a0_ready;
    logic [A_W-1:0] a0_bits;
    logic           a1_valid;
    logic           a1_ready;
    logic [A_W-1:0] a1_bits;
    logic           out_valid;
    logic           out_ready;
    logic [A_W:0]   out_bits;
    logic           d_valid;
    logic           d_ready;
    logic [D_W:0]   d_bits;
    logic           d0_valid;
    logic           d0_ready;
    logic           d1_valid;
    logic           d1_ready;
    logic [D_W-1:0] dq_bits;

    modport slave (
        input  a0_valid, a0_bits, a1_valid, a1_bits,
        input  out_ready, d_valid, d_bits, d0_ready, d1_ready,
        output a0_ready, a1_ready, out_valid, out_bits,
        output d_ready, d0_valid, d1_valid, dq_bits
    );

    modport master (
        output a0_valid, a0_bits, a1_valid, a1_bits,
        output out_ready, d_valid, d_bits, d0_ready, d1_ready,
        input  a0_ready, a1_ready, out_valid, out_bits,
        input  d_ready, d0_valid, d1_valid, dq_bits
    );

endinterface

// File: rtl/tl_a_arb2_ctrl_rr.sv
// Round-robin grant for two requesters with a lock held for the length of a
// multi-beat A burst.
module tl_a_arb2_ctrl_rr
    import tl_a_arb2_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              fire_i,
    input  logic [BEAT_W-1:0] beats_i,
    output logic              gnt_o,
    output logic              gnt_vld_o
);

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // A tie goes to the port that did not win last time.
    assign gnt_o = (state_q == ST_BURST) ? owner_q :
                   (req0_i & req1_i)     ? ~last_q : req1_i;
    assign gnt_vld_o = (state_q == ST_BURST) | req0_i | req1_i;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fire_i) begin
                    last_d = gnt_o;
                    if (beats_i > BEAT_W'(1)) begin
                        owner_d = gnt_o;
                        cnt_d   = CNT_W'(beats_i - BEAT_W'(1));
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (fire_i) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/tl_a_arb2_ctrl.sv
// Burst-aware 2:1 TL-UL arbiter: muxes A onto one slave port tagging the
// requester ID into the source MSB, and routes D back by that bit.
module tl_a_arb2_ctrl
    import tl_a_arb2_ctrl_pkg::*;
(
    input logic             clock,
    input logic             reset,
    tl_a_arb2_ctrl_if.slave bus
);

    logic              gnt;
    logic              gnt_vld;
    logic              fire;
    logic              d_sel;
    logic [A_W-1:0]    a_sel;
    logic [BEAT_W-1:0] beats;

    tl_a_arb2_ctrl_rr u_rr (
        .clock     (clock),
        .reset     (reset),
        .req0_i    (bus.a0_valid),
        .req1_i    (bus.a1_valid),
        .fire_i    (fire),
        .beats_i   (beats),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld)
    );

    assign a_sel = gnt ? bus.a1_bits : bus.a0_bits;
    assign beats = tl_beats(a_sel[A_OPC_LSB +: 3], a_sel[A_SIZE_LSB +: SZ_W]);

    assign bus.out_valid = gnt_vld & (gnt ? bus.a1_valid : bus.a0_valid);
    assign bus.a0_ready  = gnt_vld & ~gnt & bus.out_ready;
    assign bus.a1_ready  = gnt_vld &  gnt & bus.out_ready;
    assign fire          = bus.out_valid & bus.out_ready;

    // Grant ID becomes the new source MSB; fields above it shift up one bit.
    assign bus.out_bits = {a_sel[A_W-1:A_SRC_LSB+SRC_W], gnt,
                           a_sel[A_SRC_LSB+SRC_W-1:0]};

    assign d_sel        = bus.d_bits[D_SRC_LSB+SRC_W];
    assign bus.d0_valid = bus.d_valid & ~d_sel;
    assign bus.d1_valid = bus.d_valid &  d_sel;
    assign bus.d_ready  = d_sel ? bus.d1_ready : bus.d0_ready;
    assign bus.dq_bits  = {bus.d_bits[D_W:D_SRC_LSB+SRC_W+1],
                           bus.d_bits[D_SRC_LSB+SRC_W-1:0]};

endmodule

// File: tb/tb_tl_a_arb2_ctrl.sv
// Self-checking bench for tl_a_arb2_ctrl: D routing table, directed burst
// sequences and a randomized run against a transaction-level model.
module tb_tl_a_arb2_ctrl;
    import tl_a_arb2_ctrl_pkg::*;

    typedef struct {
        logic [2:0]       opc;
        logic [2:0]       prm;
        logic [SZ_W-1:0]  sz;
        logic [SRC_W-1:0] src;
        logic [31:0]      addr;
        logic [7:0]       mask;
        logic [63:0]      data;
    } areq_t;

    typedef struct {
        logic [2:0]       opc;
        logic [1:0]       prm;
        logic [SZ_W-1:0]  sz;
        logic [SRC_W-1:0] src;
        logic             den;
        logic [63:0]      data;
    } dresp_t;

    typedef struct {
        logic dv, id, r0, r1;
        logic e0, e1, er;
    } dvec_t;

    logic clk, rst;
    int   total, bad;
    int   m_owner, m_left, m_last, last_g;

    tl_a_arb2_ctrl_if bus ();

    tl_a_arb2_ctrl dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [A_W-1:0] mk_a(input areq_t r);
        return {r.opc, r.prm, r.sz, r.src, r.addr, r.mask, r.data};
    endfunction

    function automatic logic [A_W:0] mk_out(input areq_t r, input logic g);
        return {r.opc, r.prm, r.sz, g, r.src, r.addr, r.mask, r.data};
    endfunction

    function automatic logic [D_W:0] mk_d(input dresp_t f, input logic id);
        return {f.opc, f.prm, f.sz, id, f.src, f.den, f.data};
    endfunction

    function automatic logic [D_W-1:0] mk_dq(input dresp_t f);
        return {f.opc, f.prm, f.sz, f.src, f.den, f.data};
    endfunction

    function automatic int ref_beats(input logic [2:0] opc, input int sz);
        int s;
        s = (sz > MAX_SIZE) ? MAX_SIZE : sz;
        if (opc <= 3'd3 && s > 3) return 2 ** (s - 3);
        return 1;
    endfunction

    function automatic areq_t mk_req(input int opc, input int sz, input int src);
        areq_t r;
        r.opc  = 3'(opc);
        r.prm  = 3'($urandom_range(0, 7));
        r.sz   = SZ_W'(sz);
        r.src  = SRC_W'(src);
        r.addr = $urandom;
        r.mask = 8'($urandom);
        r.data = {$urandom, $urandom};
        return r;
    endfunction

    function automatic areq_t rnd_req();
        return mk_req($urandom_range(0, 5), $urandom_range(0, MAX_SIZE),
                      $urandom_range(0, 15));
    endfunction

    function automatic dresp_t rnd_d();
        dresp_t f;
        f.opc  = 3'($urandom_range(0, 7));
        f.prm  = 2'($urandom);
        f.sz   = SZ_W'($urandom);
        f.src  = SRC_W'($urandom);
        f.den  = 1'($urandom);
        f.data = {$urandom, $urandom};
        return f;
    endfunction

    // One A-channel cycle: drive, check against the model, advance the model.
    task automatic cyc(input logic v0, input areq_t r0, input logic v1,
                       input areq_t r1, input logic ordy, input string tg);
        int   g;
        int   nb;
        logic ev;
        @(negedge clk);
        bus.a0_valid  = v0;
        bus.a0_bits   = mk_a(r0);
        bus.a1_valid  = v1;
        bus.a1_bits   = mk_a(r1);
        bus.out_ready = ordy;
        #1;
        g = -1;
        if (m_left > 0)       g = m_owner;
        else if (v0 && v1)    g = 1 - m_last;
        else if (v0)          g = 0;
        else if (v1)          g = 1;
        ev = (g == 0) ? v0 : (g == 1) ? v1 : 1'b0;
        chk({tg, " out_valid"}, 128'(bus.out_valid), 128'(ev));
        chk({tg, " a0_ready"}, 128'(bus.a0_ready), 128'(ordy && g == 0));
        chk({tg, " a1_ready"}, 128'(bus.a1_ready), 128'(ordy && g == 1));
        last_g = -1;
        if (ev) begin
            chk({tg, " out_bits"}, 128'(bus.out_bits),
                128'(mk_out((g == 1) ? r1 : r0, g == 1)));
            if (ordy) begin
                last_g = g;
                if (m_left > 0) begin
                    m_left--;
                end else begin
                    m_last = g;
                    nb = (g == 1) ? ref_beats(r1.opc, int'(r1.sz))
                                  : ref_beats(r0.opc, int'(r0.sz));
                    if (nb > 1) begin
                        m_owner = g;
                        m_left  = nb - 1;
                    end
                end
            end
        end
    endtask

    task automatic dchk(input logic dv, input logic id, input logic r0,
                        input logic r1, input logic e0, input logic e1,
                        input logic er, input string tg);
        dresp_t f;
        f = rnd_d();
        bus.d_valid  = dv;
        bus.d_bits   = mk_d(f, id);
        bus.d0_ready = r0;
        bus.d1_ready = r1;
        #1;
        chk({tg, " d0_valid"}, 128'(bus.d0_valid), 128'(e0));
        chk({tg, " d1_valid"}, 128'(bus.d1_valid), 128'(e1));
        chk({tg, " d_ready"}, 128'(bus.d_ready), 128'(er));
        chk({tg, " dq_bits"}, 128'(bus.dq_bits), 128'(mk_dq(f)));
    endtask

    task automatic idle_inputs();
        bus.a0_valid  = 1'b0;
        bus.a0_bits   = '0;
        bus.a1_valid  = 1'b0;
        bus.a1_bits   = '0;
        bus.out_ready = 1'b1;
        bus.d_valid   = 1'b0;
        bus.d_bits    = '0;
        bus.d0_ready  = 1'b1;
        bus.d1_ready  = 1'b1;
    endtask

    // Reset is raised between clock edges to exercise the asynchronous path.
    task automatic do_reset(input string tg);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        #1;
        chk({tg, " rst out_valid"}, 128'(bus.out_valid), 128'(0));
        chk({tg, " rst a0_ready"}, 128'(bus.a0_ready), 128'(0));
        chk({tg, " rst a1_ready"}, 128'(bus.a1_ready), 128'(0));
        chk({tg, " rst d0_valid"}, 128'(bus.d0_valid), 128'(0));
        chk({tg, " rst d1_valid"}, 128'(bus.d1_valid), 128'(0));
        @(negedge clk);
        rst     = 1'b0;
        m_owner = 0;
        m_left  = 0;
        m_last  = 1;
    endtask

    initial begin
        dvec_t dtab[8];
        areq_t ga, gb, pa, x;
        int    n0;
        logic  v0, v1, dv, id, r0, r1;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        m_owner = 0;
        m_left  = 0;
        m_last  = 1;
        last_g  = -1;

        dtab[0] = '{1, 1, 0, 0, 0, 1, 0};
        dtab[1] = '{1, 1, 0, 1, 0, 1, 1};
        dtab[2] = '{1, 0, 1, 0, 1, 0, 1};
        dtab[3] = '{1, 0, 0, 1, 1, 0, 0};
        dtab[4] = '{0, 1, 1, 1, 0, 0, 1};
        dtab[5] = '{0, 0, 0, 0, 0, 0, 0};
        dtab[6] = '{1, 1, 1, 0, 0, 1, 0};
        dtab[7] = '{0, 0, 1, 0, 0, 0, 1};

        do_reset("init");
        x = mk_req(4, 0, 0);

        for (int i = 0; i < 8; i++)
            dchk(dtab[i].dv, dtab[i].id, dtab[i].r0, dtab[i].r1,
                 dtab[i].e0, dtab[i].e1, dtab[i].er, $sformatf("dtab%0d", i));

        // Single Get from port 0 is granted in the same cycle.
        do_reset("t1");
        ga = mk_req(4, 2, 5);
        cyc(1, ga, 0, x, 1, "t1a");
        chk("t1 src", 128'(bus.out_bits[A_SRC_LSB +: SRC_W+1]), 128'(5'h05));
        cyc(0, x, 1, mk_req(4, 2, 3), 1, "t1b");
        chk("t1 grant1", 128'(last_g), 128'(1));

        // Ties alternate starting with port 0.
        do_reset("t2");
        for (int i = 0; i < 6; i++) begin
            cyc(1, mk_req(4, 3, i), 1, mk_req(4, 3, i + 8), 1, "t2");
            chk($sformatf("t2 alt%0d", i), 128'(last_g), 128'(i % 2));
        end

        // An 8-beat burst from port 1 locks out port 0.
        do_reset("t3");
        cyc(1, mk_req(4, 0, 1), 0, x, 1, "t3pre");
        gb = mk_req(0, 6, 2);
        for (int i = 0; i < 8; i++) begin
            cyc(1, mk_req(4, 0, 1), 1, gb, 1, "t3");
            chk($sformatf("t3 beat%0d", i), 128'(last_g), 128'(1));
        end
        cyc(1, mk_req(4, 0, 1), 1, gb, 1, "t3post");
        chk("t3 beat9", 128'(last_g), 128'(0));

        // 4-beat burst under a stalling slave.
        do_reset("t4");
        pa = mk_req(0, 5, 6);
        n0 = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, pa, 1, mk_req(4, 1, 7), (i % 2) == 0, "t4");
            if (last_g == 0) n0++;
        end
        chk("t4 fires", 128'(n0), 128'(4));
        cyc(1, pa, 1, mk_req(4, 1, 7), 1, "t4post");
        chk("t4 release", 128'(last_g), 128'(1));

        // Reset abandons an in-flight burst; next tie goes to port 0.
        do_reset("t6");
        pa = mk_req(0, 6, 9);
        for (int i = 0; i < 3; i++)
            cyc(1, pa, 1, mk_req(4, 0, 2), 1, "t6");
        do_reset("t6mid");
        cyc(1, mk_req(4, 0, 3), 1, mk_req(4, 0, 4), 1, "t6tie");
        chk("t6 tie", 128'(last_g), 128'(0));

        // Randomized traffic with legal burst behaviour.
        do_reset("rnd");
        for (int i = 0; i < 1500; i++) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            if (m_left > 0) begin
                if (m_owner == 0) v0 = 1'b1;
                else              v1 = 1'b1;
            end
            cyc(v0, rnd_req(), v1, rnd_req(), $urandom_range(0, 3) != 0, "rnd");
            dv = 1'($urandom);
            id = 1'($urandom);
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            dchk(dv, id, r0, r1, dv & ~id, dv & id, id ? r1 : r0, "rndd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
